// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: data width, NOP encoding, reset PC and fetch FSM states.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT,
    RUN
  } ifetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage signal bundle: imem request/response, redirect from execute, instruction to decode.
interface ifetch_unit_if;
  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [rv_pkg::XLEN-1:0]  imem_req_addr;
  logic                     imem_rsp_valid;
  logic [rv_pkg::XLEN-1:0]  imem_rsp_data;
  logic                     redirect_valid;
  logic [rv_pkg::XLEN-1:0]  redirect_pc;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [rv_pkg::XLEN-1:0]  instr;
  logic [rv_pkg::XLEN-1:0]  instr_pc;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and a registered head entry; the head register holds its last value when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic          head_valid_o,
  output logic [W-1:0]  head_data_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          head_valid_q, head_valid_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // If the queue drains to nothing but the push, the pushed word becomes the head directly.
      if (count_d != '0)
        head_d = (count_q == CW'(do_pop)) ? push_data_i : mem_q[rd_ptr_d];
    end
    head_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(do_push && !do_pop && count_q == CW'(DEPTH)));
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_q;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: credit-limited in-order imem requests, response buffering, redirect flush.
// state | meaning
// BOOT  | first cycle after reset release, no request issued
// RUN   | normal operation, requests gated only by credit and redirect
module ifetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = 2 * XLEN;

  ifetch_state_e   state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_valid, fifo_push, fifo_flush;
  logic [FW-1:0]   fifo_head;
  logic            pop, req_valid, req_accept;
  logic [CW:0]     in_use;

  // Credit counts in-flight plus buffered words, so every response always has a FIFO slot.
  assign pop        = fifo_valid & bus.instr_ready;
  assign in_use     = {1'b0, out_cnt_q} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
  assign req_valid  = (state_q == RUN) && !bus.redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign req_accept = req_valid & bus.imem_req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    out_cnt_d  = out_cnt_q + CW'(req_accept) - CW'(bus.imem_rsp_valid);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = align_word(bus.redirect_pc);
      rsp_pc_d   = align_word(bus.redirect_pc);
      drop_cnt_d = out_cnt_q - CW'(bus.imem_rsp_valid);
      fifo_flush = 1'b1;
    end else begin
      if (req_accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (bus.imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + XLEN'(4);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (fifo_push),
    .push_data_i  ({bus.imem_rsp_data, rsp_pc_q}),
    .pop_i        (pop),
    .flush_i      (fifo_flush),
    .count_o      (fifo_cnt),
    .head_valid_o (fifo_valid),
    .head_data_o  (fifo_head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = fifo_valid;
  assign bus.instr          = fifo_valid ? fifo_head[FW-1:XLEN] : NOP_INSTR;
  assign bus.instr_pc       = fifo_head[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.imem_rsp_valid && out_cnt_q == '0));
      assert (out_cnt_q <= CW'(DEPTH));
      assert (drop_cnt_q <= out_cnt_q);
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a queue-level model of memory, buffer and redirect rules checks every cycle.
module tb_ifetch_unit;
  import rv_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  // Model: mq = accepted fetch addresses awaiting a response, bq = PCs buffered for decode.
  logic [31:0] mq[$];
  int          mq_due[$];
  logic [31:0] bq[$];
  logic [31:0] m_fetch_pc, m_head_pc;
  int          m_drop;
  bit          m_run;
  int          cyc = 0;

  int k_rdy, k_ird, k_rsp, k_lat, k_redir;
  bit          f_redir = 1'b0;
  logic [31:0] f_redir_pc;

  bit          o_ivalid, o_acc, o_pop;
  logic [31:0] o_addr, o_pop_pc;

  task automatic step();
    bit rsp, redir, pop, exp_rv, acc;
    logic [31:0] rpc, a;
    a = '0;
    bus.imem_req_ready = ($urandom_range(99) < k_rdy);
    bus.instr_ready    = ($urandom_range(99) < k_ird);
    rsp = (mq.size() > 0) && (mq_due[0] <= cyc) && ($urandom_range(99) < k_rsp);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(mq[0]) : $urandom();
    redir = f_redir || ($urandom_range(999) < k_redir);
    rpc   = f_redir ? f_redir_pc : ($urandom() & 32'h0000_FFFF);
    f_redir = 1'b0;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;

    @(negedge clk);
    pop    = (bq.size() > 0) && bus.instr_ready;
    exp_rv = m_run && !redir && (mq.size() + bq.size() - int'(pop) < DEPTH);
    check_eq("instr_valid", bus.instr_valid, bq.size() > 0);
    check_eq("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) check_eq("req_addr", bus.imem_req_addr, m_fetch_pc);
    if (bq.size() > 0) begin
      check_eq("instr_pc", bus.instr_pc, bq[0]);
      check_eq("instr", bus.instr, mem_word(bq[0]));
    end else begin
      check_eq("instr_nop", bus.instr, NOP_INSTR);
      check_eq("instr_pc_hold", bus.instr_pc, m_head_pc);
    end
    acc      = exp_rv && bus.imem_req_ready;
    o_ivalid = bus.instr_valid;
    o_acc    = acc;
    o_addr   = bus.imem_req_addr;
    o_pop    = pop;
    if (pop) o_pop_pc = bq[0];

    if (pop) void'(bq.pop_front());
    if (rsp) begin
      a = mq.pop_front();
      void'(mq_due.pop_front());
    end
    if (redir) begin
      m_drop     = mq.size();
      bq.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (rsp) begin
        if (m_drop > 0) m_drop--;
        else bq.push_back(a);
      end
      if (acc) begin
        mq.push_back(m_fetch_pc);
        mq_due.push_back(cyc + 1 + int'($urandom_range(k_lat)));
        m_fetch_pc += 32'd4;
      end
    end
    if (bq.size() > 0) m_head_pc = bq[0];
    m_run = 1'b1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    mq_due.delete();
    bq.delete();
    m_drop     = 0;
    m_fetch_pc = RST_PC;
    m_head_pc  = '0;
    m_run      = 1'b0;
  endtask

  task automatic set_knobs(input int rdy, input int ird, input int rsp, input int lat, input int redir);
    k_rdy = rdy; k_ird = ird; k_rsp = rsp; k_lat = lat; k_redir = redir;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (o_pop) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, seen, 1);
    if (seen) check_eq(tag, o_pop_pc, exp);
  endtask

  initial begin
    int first, nvalid, nacc;
    logic [31:0] a0;
    bit seen;

    set_knobs(100, 100, 100, 0, 0);
    do_reset(3);
    check_eq("rst_ivalid", bus.instr_valid, 0);
    check_eq("rst_instr", bus.instr, NOP_INSTR);
    check_eq("rst_pc", bus.instr_pc, 0);

    // Streaming latency and throughput.
    first = -1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_ivalid) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    check_eq("first_lat", first, 3);
    check_eq("sustain", nvalid, 9);

    // Decode stalled: exactly DEPTH requests, then in-order release.
    do_reset(1);
    set_knobs(100, 0, 100, 0, 0);
    nacc = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_acc) nacc++;
    end
    check_eq("stall_reqs", nacc, DEPTH);
    check_eq("stall_rv", bus.imem_req_valid, 0);
    k_ird = 100;
    wait_pop("stall_pc0", 32'h0);
    wait_pop("stall_pc1", 32'h4);
    wait_pop("stall_pc2", 32'h8);
    wait_pop("stall_pc3", 32'hC);

    // Memory not ready: address must hold.
    k_rdy = 0;
    step();
    a0 = o_addr;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("addr_hold", o_addr, a0);
    end
    k_rdy = 100;

    // Redirect with slow memory and a partly stalled decoder.
    set_knobs(100, 30, 100, 2, 0);
    repeat (8) step();
    f_redir = 1'b1; f_redir_pc = 32'h100;
    step();
    wait_pop("redir_pc0", 32'h100);
    wait_pop("redir_pc1", 32'h104);

    // Unaligned target.
    set_knobs(100, 100, 100, 0, 0);
    f_redir = 1'b1; f_redir_pc = 32'h203;
    step();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (o_acc) seen = 1'b1;
    end
    check_eq("unal_seen", seen, 1);
    if (seen) check_eq("unal_addr", o_addr, 32'h200);

    // Back-to-back redirects, last wins.
    f_redir = 1'b1; f_redir_pc = 32'h40;
    step();
    f_redir = 1'b1; f_redir_pc = 32'h80;
    step();
    wait_pop("b2b_pc", 32'h80);

    // Reset mid-operation with full buffer and traffic in flight.
    set_knobs(100, 0, 60, 2, 0);
    repeat (10) step();
    do_reset(1);
    check_eq("mid_rst_ivalid", bus.instr_valid, 0);
    check_eq("mid_rst_instr", bus.instr, NOP_INSTR);
    set_knobs(100, 100, 100, 0, 0);
    wait_pop("mid_rst_pc", RST_PC);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 20), $urandom_range(100, 30),
                $urandom_range(3), $urandom_range(60));
      if (it % 13 == 7) do_reset(1 + $urandom_range(2));
      repeat (100) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
